// File: rtl/nco_if.sv
// Sample-strobe, tuning-word handshake and sample output bundle of the NCO.
// The DUT connects through "slave"; whatever drives and observes it uses "master".
interface nco_if #(
   parameter int PHASE_W = 32
);
   logic                     i_enable;
   logic                     i_ce;
   logic [PHASE_W-1:0]       i_fcw;
   logic                     i_fcw_valid;
   logic                     o_fcw_ready;
   logic [PHASE_W-1:0]       i_phase_offset;
   logic signed [7:0]        o_data;
   logic                     o_valid;
   logic                     o_wrap;

   modport slave (
      input  i_enable, i_ce, i_fcw, i_fcw_valid, i_phase_offset,
      output o_fcw_ready, o_data, o_valid, o_wrap
   );

   modport master (
      output i_enable, i_ce, i_fcw, i_fcw_valid, i_phase_offset,
      input  o_fcw_ready, o_data, o_valid, o_wrap
   );
endinterface

// File: rtl/nco.sv
// Numerically controlled oscillator: phase accumulator, wrap-synchronised tuning-word
// update and a quarter-wave sine ROM, three register stages from strobe to sample.
module nco #(
   parameter int PHASE_W = 32
) (
   input  logic i_clk,
   input  logic i_reset,
   nco_if.slave bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [6:0] SINE_QW [64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
   };

   logic [0:0]         state_q,      state_d;
   logic [PHASE_W-1:0] acc_q,        acc_d;
   logic [PHASE_W-1:0] fcw_q,        fcw_d;
   logic [PHASE_W-1:0] pend_fcw_q,   pend_fcw_d;
   logic               pend_valid_q, pend_valid_d;

   logic               s1_valid_q, s1_valid_d;
   logic               s1_wrap_q,  s1_wrap_d;
   logic [7:0]         s1_k_q,     s1_k_d;
   logic               s2_valid_q, s2_valid_d;
   logic               s2_wrap_q,  s2_wrap_d;
   logic               s2_neg_q,   s2_neg_d;
   logic [6:0]         s2_mag_q,   s2_mag_d;
   logic [7:0]         data_q,     data_d;
   logic               valid_q,    valid_d;
   logic               wrap_q,     wrap_d;

   logic [PHASE_W:0]   acc_sum;
   logic [PHASE_W-1:0] phase;
   logic               carry;
   logic               fcw_xfer;
   logic               sample;
   logic [5:0]         rom_addr;
   logic [7:0]         mag8;

   assign acc_sum  = {1'b0, acc_q} + {1'b0, fcw_q};
   assign carry    = acc_sum[PHASE_W];
   assign phase    = acc_q + bus.i_phase_offset;
   assign fcw_xfer = bus.i_fcw_valid & ~pend_valid_q;
   assign sample   = (state_q == S_RUN) & bus.i_enable & bus.i_ce;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = bus.i_enable ? S_RUN : S_IDLE;
      acc_d        = acc_q;
      fcw_d        = fcw_q;
      pend_fcw_d   = pend_fcw_q;
      pend_valid_d = pend_valid_q;

      if (state_q == S_IDLE) begin
         acc_d = '0;
         if (fcw_xfer) fcw_d = bus.i_fcw;
      end else begin
         if (!bus.i_enable) begin
            acc_d = '0;
         end else if (bus.i_ce) begin
            acc_d = acc_sum[PHASE_W-1:0];
            // Swap only at a wrap, while this add still uses the old word.
            if (carry && pend_valid_q) begin
               fcw_d        = pend_fcw_q;
               pend_valid_d = 1'b0;
            end
         end
         if (fcw_xfer) begin
            pend_fcw_d   = bus.i_fcw;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      s1_valid_d = sample;
      s1_wrap_d  = sample & carry;
      s1_k_d     = phase[PHASE_W-1 -: 8];

      // Odd quadrants read the table mirrored; the mirror of index 0 is the peak.
      rom_addr   = s1_k_q[6] ? (6'd0 - s1_k_q[5:0]) : s1_k_q[5:0];
      s2_valid_d = s1_valid_q;
      s2_wrap_d  = s1_wrap_q;
      s2_neg_d   = s1_k_q[7];
      s2_mag_d   = (s1_k_q[6] && (s1_k_q[5:0] == 6'd0)) ? 7'd127 : SINE_QW[rom_addr];

      mag8       = {1'b0, s2_mag_q};
      valid_d    = s2_valid_q;
      wrap_d     = s2_wrap_q;
      data_d     = data_q;
      if (s2_valid_q) data_d = s2_neg_q ? (8'd0 - mag8) : mag8;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         fcw_q        <= '0;
         pend_fcw_q   <= '0;
         pend_valid_q <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_wrap_q    <= 1'b0;
         s1_k_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_wrap_q    <= 1'b0;
         s2_neg_q     <= 1'b0;
         s2_mag_q     <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         fcw_q        <= fcw_d;
         pend_fcw_q   <= pend_fcw_d;
         pend_valid_q <= pend_valid_d;
         s1_valid_q   <= s1_valid_d;
         s1_wrap_q    <= s1_wrap_d;
         s1_k_q       <= s1_k_d;
         s2_valid_q   <= s2_valid_d;
         s2_wrap_q    <= s2_wrap_d;
         s2_neg_q     <= s2_neg_d;
         s2_mag_q     <= s2_mag_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         wrap_q       <= wrap_d;
      end
   end

   assign bus.o_fcw_ready = ~pend_valid_q;
   assign bus.o_data      = data_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_wrap      = wrap_q;

endmodule

// File: tb/tb_nco.sv
// Directed bench for nco: reset, quadrature tone, full sine table, pending and
// colliding tuning-word updates, DC offset with gapped strobe, and mid-run reset.
module tb_nco;
   localparam int PW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   nco_if #(.PHASE_W(PW)) bus ();

   nco #(.PHASE_W(PW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int quad[4]   = '{0, 127, 0, -127};
   int eighth[8] = '{0, 90, 127, 90, 0, -90, -127, -90};
   bit ce_at[18];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] s8(input int v);
      logic [7:0] b;
      b = v[7:0];
      return {56'd0, b};
   endfunction

   function automatic int sine_ref(input int k);
      real r;
      r = 127.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
      if (r >= 0.0) return $rtoi($floor(r + 0.5));
      else          return -$rtoi($floor(-r + 0.5));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_sample(input string tag, input int d, input bit w);
      step();
      check({tag, ".valid"}, {63'd0, bus.o_valid}, 64'd1);
      check({tag, ".data"},  {56'd0, bus.o_data},  s8(d));
      check({tag, ".wrap"},  {63'd0, bus.o_wrap},  {63'd0, w});
   endtask

   task automatic do_reset();
      bus.i_enable = 1'b0;
      bus.i_ce = 1'b0;
      bus.i_fcw_valid = 1'b0;
      bus.i_phase_offset = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load_idle(input logic [PW-1:0] v);
      bus.i_fcw = v;
      bus.i_fcw_valid = 1'b1;
      step();
      bus.i_fcw_valid = 1'b0;
   endtask

   // Enters RUN, then issues two strobes; no sample may appear yet.
   task automatic start_run(input string tag);
      bus.i_enable = 1'b1;
      step();
      bus.i_ce = 1'b1;
      step();
      check({tag, ".lat1"}, {63'd0, bus.o_valid}, 64'd0);
      step();
      check({tag, ".lat2"}, {63'd0, bus.o_valid}, 64'd0);
   endtask

   initial begin
      bus.i_enable = 1'b0;
      bus.i_ce = 1'b0;
      bus.i_fcw = '0;
      bus.i_fcw_valid = 1'b0;
      bus.i_phase_offset = '0;

      // Reset values, asynchronously
      #1 rst = 1'b1;
      #1;
      check("rst.valid", {63'd0, bus.o_valid},     64'd0);
      check("rst.data",  {56'd0, bus.o_data},      64'd0);
      check("rst.wrap",  {63'd0, bus.o_wrap},      64'd0);
      check("rst.ready", {63'd0, bus.o_fcw_ready}, 64'd1);
      step();
      rst = 1'b0;

      // Strobes are ignored in IDLE
      bus.i_ce = 1'b1;
      step(); step(); step();
      check("idle.ce", {63'd0, bus.o_valid}, 64'd0);
      bus.i_ce = 1'b0;

      // Quadrature tone
      load_idle(32'h4000_0000);
      check("quad.ready", {63'd0, bus.o_fcw_ready}, 64'd1);
      start_run("quad");
      for (int i = 0; i < 8; i++) exp_sample("quad", quad[i % 4], (i % 4) == 3);

      // Drain, leave RUN, come back: accumulator restarts at 0, fcw kept
      bus.i_ce = 1'b0;
      exp_sample("drain0", 0, 1'b0);
      exp_sample("drain1", 127, 1'b0);
      step();
      check("drain.idle", {63'd0, bus.o_valid}, 64'd0);
      bus.i_enable = 1'b0;
      step();
      start_run("rerun");
      for (int i = 0; i < 4; i++) exp_sample("rerun", quad[i], i == 3);

      // Pending update applied at the next wrap
      do_reset();
      load_idle(32'h4000_0000);
      start_run("pend");
      bus.i_fcw = 32'h2000_0000;
      bus.i_fcw_valid = 1'b1;
      exp_sample("pend", 0, 1'b0);
      check("pend.ready0", {63'd0, bus.o_fcw_ready}, 64'd0);
      bus.i_fcw_valid = 1'b0;
      exp_sample("pend", 127, 1'b0);
      check("pend.ready1", {63'd0, bus.o_fcw_ready}, 64'd1);
      exp_sample("pend", 0, 1'b0);
      exp_sample("pend", -127, 1'b1);
      for (int i = 0; i < 8; i++) exp_sample("pend.new", eighth[i], i == 7);

      // Transfer on the wrap edge waits one more period
      do_reset();
      load_idle(32'h4000_0000);
      start_run("coll");
      exp_sample("coll", 0, 1'b0);
      bus.i_fcw = 32'h2000_0000;
      bus.i_fcw_valid = 1'b1;
      exp_sample("coll", 127, 1'b0);
      check("coll.ready0", {63'd0, bus.o_fcw_ready}, 64'd0);
      bus.i_fcw_valid = 1'b0;
      exp_sample("coll", 0, 1'b0);
      exp_sample("coll", -127, 1'b1);
      exp_sample("coll", 0, 1'b0);
      check("coll.ready1", {63'd0, bus.o_fcw_ready}, 64'd0);
      exp_sample("coll", 127, 1'b0);
      check("coll.ready2", {63'd0, bus.o_fcw_ready}, 64'd1);
      exp_sample("coll", 0, 1'b0);
      exp_sample("coll", -127, 1'b1);
      for (int i = 0; i < 8; i++) exp_sample("coll.new", eighth[i], i == 7);

      // Full 256-entry table
      do_reset();
      load_idle(32'h0100_0000);
      start_run("tbl");
      for (int k = 0; k < 256; k++) begin
         exp_sample("tbl", sine_ref(k), k == 255);
         if (k == 32)  check("tbl.k32",  {56'd0, bus.o_data}, s8(90));
         if (k == 64)  check("tbl.k64",  {56'd0, bus.o_data}, s8(127));
         if (k == 160) check("tbl.k160", {56'd0, bus.o_data}, s8(-90));
      end

      // DC via offset, strobe gapped 1-of-3
      do_reset();
      load_idle(32'h0);
      bus.i_phase_offset = 32'hC000_0000;
      bus.i_enable = 1'b1;
      step();
      for (int n = 0; n < 18; n++) begin
         bus.i_ce = (n % 3) == 0;
         step();
         ce_at[n] = bus.i_ce;
         check("dc.wrap", {63'd0, bus.o_wrap}, 64'd0);
         if (n < 2) check("dc.valid", {63'd0, bus.o_valid}, 64'd0);
         else       check("dc.valid", {63'd0, bus.o_valid}, {63'd0, ce_at[n-2]});
         if (bus.o_valid) check("dc.data", {56'd0, bus.o_data}, s8(-127));
      end
      bus.i_ce = 1'b0;
      bus.i_phase_offset = '0;

      // Reset mid-run with samples in flight and an update pending
      do_reset();
      load_idle(32'h4000_0000);
      start_run("mid");
      exp_sample("mid", 0, 1'b0);
      bus.i_fcw = 32'h2000_0000;
      bus.i_fcw_valid = 1'b1;
      exp_sample("mid", 127, 1'b0);
      check("mid.ready0", {63'd0, bus.o_fcw_ready}, 64'd0);
      bus.i_fcw_valid = 1'b0;
      bus.i_ce = 1'b0;
      bus.i_enable = 1'b0;
      rst = 1'b1;
      #1;
      check("mid.rst.valid", {63'd0, bus.o_valid},     64'd0);
      check("mid.rst.data",  {56'd0, bus.o_data},      64'd0);
      check("mid.rst.wrap",  {63'd0, bus.o_wrap},      64'd0);
      check("mid.rst.ready", {63'd0, bus.o_fcw_ready}, 64'd1);
      step();
      check("mid.rst.hold", {63'd0, bus.o_valid}, 64'd0);
      rst = 1'b0;
      step();
      check("mid.post1", {63'd0, bus.o_valid}, 64'd0);
      step();
      check("mid.post2", {63'd0, bus.o_valid}, 64'd0);
      load_idle(32'h4000_0000);
      start_run("mid.re");
      for (int i = 0; i < 6; i++) exp_sample("mid.re", quad[i % 4], (i % 4) == 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
